// File: rtl/pu_mc.sv
// pu_mc -- small multi-cycle processor core with separate instruction and
// data memory handshakes and an 8-entry register file (r0 hard-wired to 0).
// Optional feature: define PU_MC_MUL_EN to make op 5 an unsigned MUL;
// without it op 5 behaves as a NOP and no multiplier is built.
module pu_mc #(
  parameter int WIDTH = 16,
  parameter int PCW   = 8,
  parameter int DAW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PCW-1:0]   imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DAW-1:0]   dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             we,
  output logic [WIDTH-1:0] rwd,
  output logic             halt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_BZ   = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_e           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] opD_q, opD_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] regFile_q [8];

  logic [3:0]       op;
  logic [2:0]       rd, ra, rb;
  logic [8:0]       imm9;
  logic [WIDTH-1:0] immW;
  logic [PCW-1:0]   immPc;
  logic [PCW-1:0]   pcInc;

  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:9];
  assign ra    = ir_q[8:6];
  assign rb    = ir_q[5:3];
  assign imm9  = ir_q[8:0];
  assign immW  = WIDTH'($signed(imm9));
  assign immPc = PCW'($signed(imm9));
  assign pcInc = pc_q + PCW'(1);

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      opD_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      opD_q    <= opD_d;
      result_q <= result_d;
    end
  end

  // Register file: written only in WB, writes to r0 dropped so it always reads 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (state_q == WB && rd != 3'd0) begin
      regFile_q[rd] <= result_q;
    end
  end

  // Next-state logic: sequence each instruction through the FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    opD_d    = opD_q;
    result_d = result_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opA_d   = regFile_q[ra];
        opB_d   = regFile_q[rb];
        opD_d   = regFile_q[rd];
        state_d = EXEC;
      end
      EXEC: begin
        pc_d    = pcInc;
        state_d = FETCH;
        case (op)
          OP_ADD: begin result_d = opA_q + opB_q; state_d = WB; end
          OP_SUB: begin result_d = opA_q - opB_q; state_d = WB; end
          OP_AND: begin result_d = opA_q & opB_q; state_d = WB; end
          OP_OR:  begin result_d = opA_q | opB_q; state_d = WB; end
          OP_XOR: begin result_d = opA_q ^ opB_q; state_d = WB; end
`ifdef PU_MC_MUL_EN
          OP_MUL: begin result_d = opA_q * opB_q; state_d = WB; end
`endif
          OP_LI:  begin result_d = immW; state_d = WB; end
          OP_LD:  state_d = MEM;
          OP_ST:  state_d = MEM;
          OP_JMP: pc_d = PCW'(imm9);
          OP_BZ: begin
            if (opD_q == '0) begin
              pc_d = pcInc + immPc;
            end
          end
          OP_HALT: state_d = HALT;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (op == OP_LD) begin
            result_d = dmem_rdata;
            state_d  = WB;
          end else begin
            state_d  = FETCH;
          end
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output decode: every request and strobe is a pure function of the state
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    we         = 1'b0;
    rwd        = '0;
    halt       = 1'b0;
    case (state_q)
      FETCH: imem_req = 1'b1;
      MEM: begin
        dmem_req  = 1'b1;
        dmem_addr = opA_q[DAW-1:0];
        if (op == OP_ST) begin
          dmem_we    = 1'b1;
          dmem_wdata = opD_q;
        end
      end
      WB: begin
        we  = 1'b1;
        rwd = result_q;
      end
      HALT:    halt = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;

endmodule

// File: tb/tb_pu_mc.sv
// tb_pu_mc -- scoreboard bench for pu_mc: programs are loaded into a behavioural
// instruction memory, expected register write values are queued, and a monitor
// pops and compares them on every write strobe.
module tb_pu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        we;
  logic [15:0] rwd;
  logic        halt;

  pu_mc #(.WIDTH(16), .PCW(8), .DAW(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .we(we), .rwd(rwd), .halt(halt)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          imemDelay = 0;
  int          dmemDelay = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [15:0] expQ [$];
  int          weCycles [$];
  int          fetchAddr [$];
  int          fetchCyc [$];
  int          runLens [$];
  int          runAddrs [$];
  int          runWes [$];
  int          runLen = 0;
  int          runAddr = 0;
  int          runWe = 0;
  int          unstable = 0;
  int          overlapCnt = 0;
  int          rwdLeak = 0;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encR(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] encI(input logic [3:0] op, input logic [2:0] rd, input logic [8:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clearProgram();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  // Hold reset, check the reset values, then release just after a rising edge
  task automatic applyStimulus();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset imem_req", imem_req, 1);
    checkOutput("reset imem_addr", imem_addr, 0);
    checkOutput("reset we", we, 0);
    checkOutput("reset rwd", rwd, 0);
    checkOutput("reset dmem_req", dmem_req, 0);
    checkOutput("reset dmem_bus", {dmem_we, dmem_addr, dmem_wdata}, 0);
    checkOutput("reset halt", halt, 0);
    @(posedge clk); #2;
    weCycles.delete(); fetchAddr.delete(); fetchCyc.delete();
    runLens.delete(); runAddrs.delete(); runWes.delete();
    runLen = 0; unstable = 0; cyc = 0;
    rst = 1'b1;
  endtask

  task automatic waitHalt(input int budget);
    for (int i = 0; i < budget && !halt; i++) @(negedge clk);
    checkOutput("halt reached", halt, 1);
  endtask

  // Behavioural memories: answer requests just after each rising edge
  initial begin
    int iCnt = 0;
    int dCnt = 0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        if (iCnt == imemDelay) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr]; iCnt = 0;
        end else begin
          imem_ack = 1'b0; iCnt++;
        end
      end else begin
        imem_ack = 1'b0; iCnt = 0;
      end
      if (dmem_req) begin
        if (dCnt == dmemDelay) begin
          dmem_ack = 1'b1; dCnt = 0;
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          else dmem_rdata = dmem[dmem_addr];
        end else begin
          dmem_ack = 1'b0; dCnt++;
        end
      end else begin
        dmem_ack = 1'b0; dCnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (rst) cyc++;
  end

  // Monitor: pop the scoreboard on each write strobe and log bus activity
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (imem_req && dmem_req) overlapCnt++;
      if (!we && rwd != 16'h0) rwdLeak++;
      if (we) begin
        weCycles.push_back(cyc);
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected write: got rwd=0x%0h, expected no write", rwd);
        end else begin
          checkOutput("wb rwd", rwd, expQ.pop_front());
        end
      end
      if (imem_req && imem_ack) begin
        fetchAddr.push_back(imem_addr);
        fetchCyc.push_back(cyc);
      end
      if (dmem_req) begin
        if (runLen == 0) begin
          runAddr = dmem_addr; runWe = dmem_we;
        end else if (dmem_addr != runAddr[7:0] || dmem_we != runWe[0]) begin
          unstable++;
        end
        runLen++;
      end else if (runLen != 0) begin
        runLens.push_back(runLen); runAddrs.push_back(runAddr); runWes.push_back(runWe);
        runLen = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int quiet;
    int expF [10] = '{0, 10, 11, 17, 12, 15, 16, 255, 0, 1};
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Scenario A: ALU ops, LI sign extension, r0 discard, op 5
    clearProgram();
    imem[0]  = encI(4'd6, 3'd1, 9'd5);
    imem[1]  = encI(4'd6, 3'd2, 9'd3);
    imem[2]  = encR(4'd0, 3'd3, 3'd1, 3'd2);
    imem[3]  = encI(4'd6, 3'd1, 9'h1FF);
    imem[4]  = encR(4'd0, 3'd2, 3'd1, 3'd1);
    imem[5]  = encR(4'd0, 3'd0, 3'd1, 3'd1);
    imem[6]  = encR(4'd3, 3'd4, 3'd0, 3'd0);
    imem[7]  = encR(4'd1, 3'd5, 3'd3, 3'd1);
    imem[8]  = encR(4'd2, 3'd6, 3'd1, 3'd3);
    imem[9]  = encR(4'd4, 3'd7, 3'd1, 3'd3);
    imem[10] = encI(4'd6, 3'd1, 9'd7);
    imem[11] = encI(4'd6, 3'd2, 9'd6);
    imem[12] = encR(4'd5, 3'd3, 3'd1, 3'd2);
    imem[13] = encI(4'd6, 3'd5, 9'd1);
    imemDelay = 0; dmemDelay = 0;
    expQ = '{16'h0005, 16'h0003, 16'h0008, 16'hFFFF, 16'hFFFE, 16'hFFFE,
             16'h0000, 16'h0009, 16'h0008, 16'hFFF7, 16'h0007, 16'h0006};
`ifdef PU_MC_MUL_EN
    expQ.push_back(16'd42);
`endif
    expQ.push_back(16'h0001);
    applyStimulus();
    waitHalt(300);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halt) quiet++;
    end
    checkOutput("halted quiet cycles", quiet, 0);
    checkOutput("A writes pending", expQ.size(), 0);
    checkOutput("first WB cycle", weCycles.size() > 0 ? weCycles[0] : -1, 3);
    checkOutput("ADD WB spacing", weCycles.size() > 2 ? weCycles[2] - weCycles[1] : -1, 4);

    // Scenario B: store then load with data ack delayed two cycles
    clearProgram();
    imem[0] = encI(4'd6, 3'd1, 9'h055);
    imem[1] = encI(4'd6, 3'd2, 9'd4);
    imem[2] = encR(4'd8, 3'd1, 3'd2, 3'd0);
    imem[3] = encR(4'd7, 3'd3, 3'd2, 3'd0);
    imemDelay = 1; dmemDelay = 2;
    expQ = '{16'h0055, 16'h0004, 16'h0055};
    applyStimulus();
    waitHalt(300);
    checkOutput("B writes pending", expQ.size(), 0);
    checkOutput("dmem run count", runLens.size(), 2);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dmem run%0d length", i), runLens.size() > i ? runLens[i] : -1, 3);
      checkOutput($sformatf("dmem run%0d addr", i), runAddrs.size() > i ? runAddrs[i] : -1, 4);
      checkOutput($sformatf("dmem run%0d we", i), runWes.size() > i ? runWes[i] : -1, i == 0 ? 1 : 0);
    end
    checkOutput("dmem stable", unstable, 0);
    checkOutput("stored word", dmem[4], 16'h0055);

    // Scenario C: branches, jump and PC wrap
    clearProgram();
    imem[0]   = encI(4'd10, 3'd1, 9'd9);
    imem[10]  = encI(4'd6, 3'd1, 9'd1);
    imem[11]  = encI(4'd10, 3'd0, 9'd5);
    imem[17]  = encI(4'd10, 3'd0, 9'h1FA);
    imem[12]  = encI(4'd10, 3'd0, 9'd2);
    imem[15]  = encI(4'd10, 3'd1, 9'd5);
    imem[16]  = encI(4'd9, 3'd0, 9'h0FF);
    imem[255] = 16'hB000;
    imemDelay = 0; dmemDelay = 0;
    expQ = '{16'h0001};
    applyStimulus();
    waitHalt(300);
    checkOutput("C writes pending", expQ.size(), 0);
    checkOutput("fetch count", fetchAddr.size(), 10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("fetch%0d addr", i), fetchAddr.size() > i ? fetchAddr[i] : -1, expF[i]);
    checkOutput("BZ latency", fetchCyc.size() > 1 ? fetchCyc[1] - fetchCyc[0] : -1, 3);
    checkOutput("LI latency", fetchCyc.size() > 2 ? fetchCyc[2] - fetchCyc[1] : -1, 4);

    // Scenario D: one-cycle reset while a load waits for its ack
    clearProgram();
    imem[0] = encI(4'd6, 3'd2, 9'd4);
    imem[1] = encR(4'd7, 3'd3, 3'd2, 3'd0);
    imemDelay = 0; dmemDelay = 10;
    expQ = '{16'h0004};
    applyStimulus();
    quiet = 0;
    for (int i = 0; i < 100 && quiet < 2; i++) begin
      @(negedge clk);
      if (dmem_req) quiet++;
    end
    checkOutput("load reached MEM", quiet, 2);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("post-reset imem_req", imem_req, 1);
    checkOutput("post-reset pc", imem_addr, 0);
    checkOutput("post-reset dmem_req", dmem_req, 0);
    checkOutput("post-reset halt", halt, 0);
    checkOutput("post-reset we", we, 0);
    checkOutput("D writes pending", expQ.size(), 0);
    expQ.push_back(16'h0004);
    expQ.push_back(16'h0055);
    waitHalt(300);
    checkOutput("D restart writes", expQ.size(), 0);

    checkOutput("req overlap", overlapCnt, 0);
    checkOutput("rwd without we", rwdLeak, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_mc.md
PU_MC -- requirements
Module: pu_mc

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, data/register width (>=9); PCW, 8, program counter width; DAW, 8, data address width (<=WIDTH).
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  synchronous active-low reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  PCW  fetch address (=pc)
  imem_ack  in  1  fetch data valid
  imem_rdata  in  16  instruction word
  dmem_req  out  1  data access request
  dmem_we  out  1  1=store, 0=load
  dmem_addr  out  DAW  data address
  dmem_wdata  out  WIDTH  store data
  dmem_ack  in  1  access complete (load data valid)
  dmem_rdata  in  WIDTH  load data
  we  out  1  register write strobe, one cycle
  rwd  out  WIDTH  register write data
  halt  out  1  core halted
REQ-003 Reset SHALL be synchronous and active-low on rst, single clock clk.

Function
REQ-004 Encoding SHALL be: op=[15:12], rd=[11:9], ra=[8:6], rb=[5:3], imm9=[8:0], sign-extended to WIDTH/PCW where used.
REQ-005 Ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (rd<=ra op rb); 6 LI rd<=sext(imm9); 7 LD rd<=mem[ra[DAW-1:0]]; 8 ST mem[ra]<=rd; 9 JMP pc<=imm9[PCW-1:0]; 10 BZ if rd==0 pc<=pc+1+sext(imm9); 15 HALT; all others NOP.
REQ-006 Register file SHALL hold 8 x WIDTH registers; r0 reads 0 and writes to r0 are discarded (we still pulses).
REQ-007 Arithmetic SHALL be modulo 2^WIDTH; PC arithmetic modulo 2^PCW (wraps 2^PCW-1 -> 0).
REQ-008 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-009 FETCH: imem_req=1, imem_addr=pc; on edge with imem_ack=1 latch instruction, go DECODE; else stay with req and addr held.
REQ-010 DECODE: read ra/rb/rd operands; go EXEC.
REQ-011 EXEC: ALU/LI -> WB; LD/ST -> MEM; JMP/BZ/NOP update pc, -> FETCH; HALT -> HALT; pc<=pc+1 unless branch taken.
REQ-012 MEM: dmem_req=1 with addr/we/wdata stable until edge with dmem_ack=1; then ST -> FETCH, LD latch dmem_rdata -> WB.
REQ-013 WB: we=1 for exactly one cycle, rwd=result, register updated at that edge; -> FETCH.
REQ-014 Latency with ack high in first request cycle: ALU/LI 4 cycles, LD 5, ST 4, JMP/BZ/NOP 3; each wait cycle adds 1.
REQ-015 HALT: halt=1, no requests, state held until reset.
REQ-016 imem_req and dmem_req SHALL never be high in the same cycle; ack inputs outside their own request state are ignored.
REQ-017 we=0, dmem_req=0, imem_req=0 in all states not named above for them; rwd=0 when we=0.

Reset
REQ-018 On rising clk with rst=0: state=FETCH, pc=0, all registers 0, halt=0, we=0, rwd=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; imem_req=1 from the first cycle after release.
REQ-019 Reset mid-operation (including pending request) SHALL abandon the access; no register write occurs in that cycle.

Configuration
REQ-020 Macro PU_MC_MUL_EN defined: op 5 SHALL be MUL, rd<=low WIDTH bits of ra*rb (unsigned), WB timing as ADD.
REQ-021 Macro PU_MC_MUL_EN undefined: op 5 SHALL be NOP, no multiplier synthesised.

Verification
REQ-022 LI r1,5; LI r2,3; ADD r3,r1,r2 with imem_ack always 1 -> we pulses with rwd=5,3,8; ADD WB 4 cycles after its fetch start.
REQ-023 LI r1,-1 (WIDTH=16); ADD r2,r1,r1 -> rwd=0xFFFF then 0xFFFE; ADD r0,r1,r1 -> we=1, later read of r0 gives 0.
REQ-024 ST r1 at [r2=4] then LD r3,[r2] with dmem_ack delayed 2 cycles -> dmem_req held 3 cycles each with stable addr=4; rwd=stored value.
REQ-025 BZ r0,+2 at pc=3 -> next imem_addr=6; BZ with rd!=0 -> 4; JMP 255 then NOP -> imem_addr 255 then 0.
REQ-026 HALT -> halt=1, no further imem_req; rst=0 for one cycle during MEM wait -> next cycle FETCH, pc=0, dmem_req=0, halt=0.
REQ-027 op 5 with r1=7, r2=6: PU_MC_MUL_EN defined -> rwd=42; undefined -> no we pulse, next fetch at pc+1.
